// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge.
// Entry layout: {is_write, size[2:0], len[3:0], addr}.
package apb2axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int ARB_MAX_OUTSTANDING = 4;

  localparam int ENT_ADDR_OFS = 0;
  localparam int ENT_LEN_OFS = AXI_ADDR_W;
  localparam int ENT_SIZE_OFS = AXI_ADDR_W + 4;
  localparam int ENT_WR_OFS = 7;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // A done with nothing in flight is dropped, not counted.
  function automatic int cnt_next(
    int   cnt,
    logic inc,
    logic dec
  );
    return cnt + int'(inc) - int'(dec && cnt != 0);
  endfunction

endpackage

// File: rtl/apb2axi_wr_addr_tracker.sv
// In-order FIFO of outstanding write addresses with a
// parallel compare against the read head address.
module apb2axi_wr_addr_tracker
  import apb2axi_pkg::*;
#(
  parameter int AW    = AXI_ADDR_W,
  parameter int DEPTH = ARB_MAX_OUTSTANDING,
  parameter int LSB   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:LSB] addr,
  input  logic          pop,
  input  logic [AW-1:LSB] rd_addr,
  output logic          hit,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:LSB] tag_q [DEPTH];
  logic [AW-1:LSB] tag_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;

  assign full  = &vld_q;
  assign empty = ~|vld_q;

  always_comb begin
    vld_d = vld_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    tag_d = tag_q;
    if (pop && !empty) begin
      vld_d[rp_q] = 1'b0;
      rp_d = rp_q + 1'b1;
    end
    if (push && !full) begin
      vld_d[wp_q] = 1'b1;
      tag_d[wp_q] = addr;
      wp_d = wp_q + 1'b1;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && tag_q[i] == rd_addr) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/apb2axi_req_arbiter.sv
// Round-robin read/write request arbiter with per-direction
// outstanding limits and a read-after-write hazard hold.
module apb2axi_req_arbiter
  import apb2axi_pkg::*;
#(
  parameter int AXI_ADDR_W      = apb2axi_pkg::AXI_ADDR_W,
  parameter int FIFO_ENTRY_W    = 1 + 3 + 4 + AXI_ADDR_W,
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING,
  parameter int HAZ_LSB         = 2,
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [FIFO_ENTRY_W-1:0] rd_req_data,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [FIFO_ENTRY_W-1:0] wr_req_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [FIFO_ENTRY_W-1:0] cmd_data,
  input  logic                    rd_done,
  input  logic                    wr_done,
  output logic [CW-1:0]           rd_outstanding,
  output logic [CW-1:0]           wr_outstanding,
  output logic                    err_underflow
);

  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);
  localparam int WB = AXI_ADDR_W + ENT_WR_OFS;

  arb_state_e state_q, state_d;
  logic [FIFO_ENTRY_W-1:0] cmd_q, cmd_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic pref_wr_q, pref_wr_d;
  logic err_q, err_d;

  logic trk_hit, trk_full, trk_empty;
  logic can_grant, rd_elig, wr_elig;
  logic grant_rd, grant_wr;

  apb2axi_wr_addr_tracker #(
    .AW    (AXI_ADDR_W),
    .DEPTH (MAX_OUTSTANDING),
    .LSB   (HAZ_LSB)
  ) u_trk (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push    (grant_wr),
    .addr    (wr_req_data[AXI_ADDR_W-1:HAZ_LSB]),
    .pop     (wr_done && !trk_empty),
    .rd_addr (rd_req_data[AXI_ADDR_W-1:HAZ_LSB]),
    .hit     (trk_hit),
    .full    (trk_full),
    .empty   (trk_empty)
  );

  // Reset gates grants so the FIFOs are never popped in reset.
  always_comb begin
    can_grant = aresetn
             && (state_q == ARB_IDLE || cmd_ready);
    rd_elig = rd_req_valid && rd_cnt_q < MAXC && !trk_hit;
    wr_elig = wr_req_valid && wr_cnt_q < MAXC && !trk_full;
    grant_wr = can_grant && wr_elig
            && (!rd_elig || pref_wr_q);
    grant_rd = can_grant && rd_elig && !grant_wr;
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    pref_wr_d = pref_wr_q;
    unique case (state_q)
      ARB_IDLE: if (grant_wr || grant_rd) state_d = ARB_HOLD;
      ARB_HOLD: begin
        if (cmd_ready && !grant_wr && !grant_rd)
          state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    unique case (1'b1)
      grant_wr: begin
        cmd_d     = wr_req_data;
        cmd_d[WB] = 1'b1;
        pref_wr_d = 1'b0;
      end
      grant_rd: begin
        cmd_d     = rd_req_data;
        cmd_d[WB] = 1'b0;
        pref_wr_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_cnt_d = CW'(cnt_next(int'(rd_cnt_q), grant_rd, rd_done));
    wr_cnt_d = CW'(cnt_next(int'(wr_cnt_q), grant_wr, wr_done));
    err_d = err_q
         || (rd_done && rd_cnt_q == '0)
         || (wr_done && wr_cnt_q == '0);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ARB_IDLE;
      cmd_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      pref_wr_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      pref_wr_q <= pref_wr_d;
      err_q     <= err_d;
    end
  end

  assign rd_req_ready   = grant_rd;
  assign wr_req_ready   = grant_wr;
  assign cmd_valid      = state_q == ARB_HOLD;
  assign cmd_data       = cmd_q;
  assign rd_outstanding = rd_cnt_q;
  assign wr_outstanding = wr_cnt_q;
  assign err_underflow  = err_q;

endmodule
